// File: rtl/rpn_key_pkg.sv
// Shared types and helpers for the rpncalc key front-end.
//   NUM_KEYS     : number of pushbuttons handled
//   CMD_VAL_W    : default operand width of a command
//   CMD_MODE_W   : default mode width of a command
//   key_state_t  : per-key debounce FSM states
//   cmd_t        : one queued command {one-hot key, operand, mode} at the default widths
//   lowest_set() : isolates the lowest set bit of a key vector (priority select)
package rpn_key_pkg;

  localparam int NUM_KEYS   = 4;
  localparam int CMD_VAL_W  = 16;
  localparam int CMD_MODE_W = 2;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

  typedef struct packed {
    logic [NUM_KEYS-1:0]   key;
    logic [CMD_VAL_W-1:0]  val;
    logic [CMD_MODE_W-1:0] mode;
  } cmd_t;

  // Two's-complement trick: v & -v keeps only the lowest set bit.
  function automatic logic [NUM_KEYS-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    return v & (~v + NUM_KEYS'(1));
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchroniser + debounce FSM for one active-low pushbutton.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   key_raw   : raw pushbutton, active-low, asynchronous to clk
//   level     : debounced key state, active-high (1 = held)
//   press_evt : single-cycle pulse on the cycle the press is accepted
module key_debounce
  import rpn_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic press_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             s;
  key_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Synchroniser resets to "released" so a key held through reset still
  // needs a full debounce before it counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= 2'b11;
      state_reg <= RELEASED;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], key_raw};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign s = ~sync_reg[1];

  // The press event is taken from the PRESS_WAIT -> PRESSED transition, so the
  // top level can record it on the same edge the FSM enters PRESSED.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    press_evt  = 1'b0;
    unique case (state_reg)
      RELEASED: begin
        if (s) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next = RELEASED;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = PRESSED;
          press_evt  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_next = PRESSED;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = RELEASED;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: state_next = RELEASED;
    endcase
  end

  assign level = (state_reg == PRESSED) || (state_reg == RELEASE_WAIT);

endmodule

// File: rtl/rpn_key_conditioner.sv
// Turns four raw pushbuttons into queued rpncalc commands.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   KEY       : raw pushbuttons, active-low, asynchronous
//   sw_val    : switch operand, captured at each accepted press
//   sw_mode   : switch mode, captured at each accepted press
//   cmd_valid : command available; cmd_ready : consumer accepts this cycle
//   cmd_key   : one-hot key of the command; cmd_val / cmd_mode : captured switches
//   overrun   : one-cycle pulse when a press is dropped (key already pending)
//   key_level : debounced key state, active-high
module rpn_key_conditioner
  import rpn_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int VAL_W           = CMD_VAL_W,
  parameter int MODE_W          = CMD_MODE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [VAL_W-1:0]    sw_val,
  input  logic [MODE_W-1:0]   sw_mode,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [NUM_KEYS-1:0] cmd_key,
  output logic [VAL_W-1:0]    cmd_val,
  output logic [MODE_W-1:0]   cmd_mode,
  output logic                overrun,
  output logic [NUM_KEYS-1:0] key_level
);

  logic [NUM_KEYS-1:0] press_evt;
  logic [NUM_KEYS-1:0] pending_reg, pending_next;
  logic [NUM_KEYS-1:0] sel, clear, drop, capture;
  logic                load;
  logic [VAL_W-1:0]    snap_val_reg  [NUM_KEYS];
  logic [MODE_W-1:0]   snap_mode_reg [NUM_KEYS];
  logic [VAL_W-1:0]    sel_val;
  logic [MODE_W-1:0]   sel_mode;
  logic                cmd_valid_reg;
  logic [NUM_KEYS-1:0] cmd_key_reg;
  logic [VAL_W-1:0]    cmd_val_reg;
  logic [MODE_W-1:0]   cmd_mode_reg;
  logic                overrun_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key_debounce (
        .clk      (clk),
        .rst_n    (rst),
        .key_raw  (KEY[gi]),
        .level    (key_level[gi]),
        .press_evt(press_evt[gi])
      );
    end
  endgenerate

  // A key being issued this cycle is free to take a new press (set wins over
  // clear); only a press on a key that stays pending is dropped.
  always_comb begin
    load         = (!cmd_valid_reg || cmd_ready) && (|pending_reg);
    sel          = lowest_set(pending_reg);
    clear        = load ? sel : '0;
    drop         = press_evt & pending_reg & ~clear;
    capture      = press_evt & ~drop;
    pending_next = (pending_reg & ~clear) | press_evt;
  end

  // sel is one-hot (or zero), so an AND-OR mux is sufficient.
  always_comb begin
    sel_val  = '0;
    sel_mode = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sel[i]) begin
        sel_val  = sel_val | snap_val_reg[i];
        sel_mode = sel_mode | snap_mode_reg[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_reg <= '0;
      overrun_reg <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        snap_val_reg[i]  <= '0;
        snap_mode_reg[i] <= '0;
      end
    end else begin
      pending_reg <= pending_next;
      overrun_reg <= |drop;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (capture[i]) begin
          snap_val_reg[i]  <= sw_val;
          snap_mode_reg[i] <= sw_mode;
        end
      end
    end
  end

  // Output register: reloads only when empty or being consumed, so the
  // payload stays stable under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_valid_reg <= 1'b0;
      cmd_key_reg   <= '0;
      cmd_val_reg   <= '0;
      cmd_mode_reg  <= '0;
    end else if (load) begin
      cmd_valid_reg <= 1'b1;
      cmd_key_reg   <= sel;
      cmd_val_reg   <= sel_val;
      cmd_mode_reg  <= sel_mode;
    end else if (cmd_ready) begin
      cmd_valid_reg <= 1'b0;
    end
  end

  assign cmd_valid = cmd_valid_reg;
  assign cmd_key   = cmd_key_reg;
  assign cmd_val   = cmd_val_reg;
  assign cmd_mode  = cmd_mode_reg;
  assign overrun   = overrun_reg;

endmodule
